// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline stage.
// master drives valid+data, slave drives ready.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer, flush-to-bubble and saturating stall counter.
// Latency 1 cycle; in_ready depends only on registered state so stalls never chain combinationally.
module pipe_stage_skid #(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  in_bus,
  pipe_stage_skid_if.master out_bus,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              push;
  logic              pop;
  logic              stall;

  assign in_bus.ready  = !skid_valid;
  assign push          = in_bus.valid & !skid_valid & !flush;
  assign pop           = main_valid & out_bus.ready;
  assign stall         = main_valid & !out_bus.ready;
  assign out_bus.valid = main_valid;
  assign out_bus.data  = main_valid ? main_data : BUBBLE;
  assign occupancy     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      // Stall counting is independent of flush so perf data survives pipeline kills.
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      if (flush) begin
        state      <= EMPTY;
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (push) begin
              state      <= ONE;
              main_valid <= 1'b1;
              main_data  <= in_bus.data;
            end
          end
          ONE: begin
            if (push && pop) begin
              main_data <= in_bus.data;
            end else if (push) begin
              state      <= FULL;
              skid_valid <= 1'b1;
              skid_data  <= in_bus.data;
            end else if (pop) begin
              state      <= EMPTY;
              main_valid <= 1'b0;
            end
          end
          FULL: begin
            // Skid entry is older than anything upstream, so it moves to head first.
            if (pop) begin
              state      <= ONE;
              skid_valid <= 1'b0;
              main_data  <= skid_data;
            end
          end
          default: begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + scoreboard bench for pipe_stage_skid (DATA_W=16, CNT_W=4, non-zero BUBBLE).
module tb_pipe_stage_skid;

  localparam int          DW  = 16;
  localparam int          CW  = 4;
  localparam logic [15:0] BUB = 16'hDEAD;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int n_vec;
  int n_err;

  pipe_stage_skid_if #(.DATA_W(DW)) in_bus ();
  pipe_stage_skid_if #(.DATA_W(DW)) out_bus ();

  pipe_stage_skid #(
    .DATA_W (DW),
    .BUBBLE (BUB),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_bus    (in_bus),
    .out_bus   (out_bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    in_bus.valid  = iv;
    in_bus.data   = id;
    out_bus.ready = ordy;
    flush         = fl;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [15:0] d,
                            input logic [1:0] occ, input logic ir);
    chk({tag, ".out_valid"}, 64'(out_bus.valid), 64'(v));
    chk({tag, ".out_data"},  64'(out_bus.data),  64'(d));
    chk({tag, ".occupancy"}, 64'(occupancy),     64'(occ));
    chk({tag, ".in_ready"},  64'(in_bus.ready),  64'(ir));
  endtask

  logic [15:0] q[$];
  int          cnt_m;
  logic        m_push;
  logic        m_pop;
  logic        m_stall;
  logic        r_iv;
  logic        r_ordy;
  logic        r_fl;
  logic [15:0] r_d;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b1, 16'h5555, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    expect_out("reset", 1'b0, BUB, 2'd0, 1'b1);
    chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);

    // Pass-through
    drive(1'b1, 16'hA1, 1'b1, 1'b0); tick(); expect_out("pt1", 1'b1, 16'hA1, 2'd1, 1'b1);
    drive(1'b1, 16'hA2, 1'b1, 1'b0); tick(); expect_out("pt2", 1'b1, 16'hA2, 2'd1, 1'b1);
    drive(1'b1, 16'hA3, 1'b1, 1'b0); tick(); expect_out("pt3", 1'b1, 16'hA3, 2'd1, 1'b1);
    drive(1'b0, 16'h00, 1'b1, 1'b0); tick(); expect_out("pt4", 1'b0, BUB, 2'd0, 1'b1);
    chk("pt.stall_cnt", 64'(stall_cnt), 64'd0);

    // Back-pressure fills skid, third item waits
    drive(1'b1, 16'hB1, 1'b0, 1'b0); tick(); expect_out("bp1", 1'b1, 16'hB1, 2'd1, 1'b1);
    drive(1'b1, 16'hB2, 1'b0, 1'b0); tick(); expect_out("bp2", 1'b1, 16'hB1, 2'd2, 1'b0);
    drive(1'b1, 16'hB3, 1'b0, 1'b0); tick(); expect_out("bp3", 1'b1, 16'hB1, 2'd2, 1'b0);
    chk("bp.stall_cnt", 64'(stall_cnt), 64'd2);
    drive(1'b1, 16'hB3, 1'b1, 1'b0); tick(); expect_out("bp4", 1'b1, 16'hB2, 2'd1, 1'b1);
    drive(1'b1, 16'hB3, 1'b1, 1'b0); tick(); expect_out("bp5", 1'b1, 16'hB3, 2'd1, 1'b1);
    drive(1'b0, 16'h00, 1'b1, 1'b0); tick(); expect_out("bp6", 1'b0, BUB, 2'd0, 1'b1);
    chk("bp.stall_hold", 64'(stall_cnt), 64'd2);

    // Flush while FULL with a same-cycle push
    drive(1'b1, 16'hD1, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hD2, 1'b0, 1'b0); tick(); expect_out("fl0", 1'b1, 16'hD1, 2'd2, 1'b0);
    drive(1'b1, 16'hD3, 1'b0, 1'b1); tick(); expect_out("fl1", 1'b0, BUB, 2'd0, 1'b1);
    chk("fl.stall_cnt", 64'(stall_cnt), 64'd4);
    drive(1'b0, 16'h00, 1'b1, 1'b0); tick(); expect_out("fl2", 1'b0, BUB, 2'd0, 1'b1);

    // Stall counter saturation
    drive(1'b1, 16'hE1, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat.stall_cnt", 64'(stall_cnt), 64'd15);
    tick();
    chk("sat.stays", 64'(stall_cnt), 64'd15);
    expect_out("sat.head", 1'b1, 16'hE1, 2'd1, 1'b1);
    drive(1'b0, 16'h00, 1'b0, 1'b1); tick();
    chk("sat.after_flush", 64'(stall_cnt), 64'd15);
    expect_out("sat.flushed", 1'b0, BUB, 2'd0, 1'b1);

    // Reset mid-operation beats flush and push
    drive(1'b1, 16'hC8, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hC9, 1'b0, 1'b0); tick(); expect_out("rst0", 1'b1, 16'hC8, 2'd2, 1'b0);
    rst = 1'b1;
    drive(1'b1, 16'h77, 1'b1, 1'b1); tick();
    rst = 1'b0;
    expect_out("rst1", 1'b0, BUB, 2'd0, 1'b1);
    chk("rst1.stall_cnt", 64'(stall_cnt), 64'd0);
    drive(1'b1, 16'hC1, 1'b0, 1'b0); tick(); expect_out("rst2", 1'b1, 16'hC1, 2'd1, 1'b1);
    chk("rst2.stall_cnt", 64'(stall_cnt), 64'd0);
    drive(1'b0, 16'h00, 1'b1, 1'b0); tick(); expect_out("rst3", 1'b0, BUB, 2'd0, 1'b1);

    // Random traffic against a queue model
    q.delete();
    cnt_m = 0;
    for (int i = 0; i < 3000; i++) begin
      r_iv = ($urandom_range(0, 3) != 0);
      r_d  = 16'($urandom);
      r_fl = ($urandom_range(0, 31) == 0);
      drive(r_iv, r_d, 1'b0, r_fl);
      #1;
      chk("rnd.in_ready_ordy0", 64'(in_bus.ready), 64'(q.size() < 2));
      r_ordy = ($urandom_range(0, 2) != 0);
      out_bus.ready = r_ordy;
      #1;
      chk("rnd.in_ready_ordy", 64'(in_bus.ready), 64'(q.size() < 2));
      m_push  = r_iv && (q.size() < 2) && !r_fl;
      m_pop   = (q.size() > 0) && r_ordy;
      m_stall = (q.size() > 0) && !r_ordy;
      tick();
      if (m_stall && cnt_m < 15) cnt_m++;
      if (r_fl) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(r_d);
      end
      expect_out("rnd", q.size() > 0, (q.size() > 0) ? q[0] : BUB, 2'(q.size()), q.size() < 2);
      chk("rnd.stall_cnt", 64'(stall_cnt), 64'(cnt_m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
